// File: rtl/mcash_req_arb.sv
// Three-channel round-robin request arbiter for the mcash pipeline port,
// with an in-order channel-ID FIFO that steers return beats back to their issuers.
module mcash_req_arb #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          ch0_req_valid_i,
    output logic          ch0_req_allowIn_o,
    input  logic [2:0]    ch0_req_op_i,
    input  logic [27:0]   ch0_req_addr_i,
    input  logic [127:0]  ch0_req_data_i,
    output logic          ch0_rtn_valid_o,
    input  logic          ch0_rtn_ready_i,
    output logic [127:0]  ch0_rtn_data_o,
    input  logic          ch1_req_valid_i,
    output logic          ch1_req_allowIn_o,
    input  logic [2:0]    ch1_req_op_i,
    input  logic [27:0]   ch1_req_addr_i,
    input  logic [127:0]  ch1_req_data_i,
    output logic          ch1_rtn_valid_o,
    input  logic          ch1_rtn_ready_i,
    output logic [127:0]  ch1_rtn_data_o,
    input  logic          ch2_req_valid_i,
    output logic          ch2_req_allowIn_o,
    input  logic [2:0]    ch2_req_op_i,
    input  logic [27:0]   ch2_req_addr_i,
    input  logic [127:0]  ch2_req_data_i,
    output logic          ch2_rtn_valid_o,
    input  logic          ch2_rtn_ready_i,
    output logic [127:0]  ch2_rtn_data_o,
    output logic          pipe_req_valid_o,
    input  logic          pipe_req_allowIn_i,
    output logic [2:0]    pipe_req_op_o,
    output logic [27:0]   pipe_req_addr_o,
    output logic [127:0]  pipe_req_data_o,
    output logic [1:0]    pipe_req_chid_o,
    input  logic          pipe_rtn_valid_i,
    output logic          pipe_rtn_ready_o,
    input  logic [127:0]  pipe_rtn_data_i,
    output logic [CW-1:0] outstanding_o,
    output logic          err_o
);

    function automatic logic [1:0] rr_idx(input logic [1:0] base,
                                          input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    logic [2:0]    req_v;
    logic [2:0]    op_a   [3];
    logic [27:0]   addr_a [3];
    logic [127:0]  data_a [3];
    logic [1:0]    rr_ptr;
    logic [CW-1:0] count;
    logic [1:0]    fifo [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    head;
    logic [2:0]    head_oh;
    logic [2:0]    rtn_rdy;
    logic          empty;
    logic          can_load;
    logic          can_issue;
    logic          win_vld;
    logic [1:0]    win;
    logic [2:0]    grant;
    logic          push;
    logic          pop;
    logic          xfer;

    assign req_v   = {ch2_req_valid_i, ch1_req_valid_i, ch0_req_valid_i};
    assign rtn_rdy = {ch2_rtn_ready_i, ch1_rtn_ready_i, ch0_rtn_ready_i};
    assign op_a[0] = ch0_req_op_i;
    assign op_a[1] = ch1_req_op_i;
    assign op_a[2] = ch2_req_op_i;
    assign addr_a[0] = ch0_req_addr_i;
    assign addr_a[1] = ch1_req_addr_i;
    assign addr_a[2] = ch2_req_addr_i;
    assign data_a[0] = ch0_req_data_i;
    assign data_a[1] = ch1_req_data_i;
    assign data_a[2] = ch2_req_data_i;

    assign xfer      = pipe_req_valid_o & pipe_req_allowIn_i;
    assign can_load  = !pipe_req_valid_o | pipe_req_allowIn_i;
    assign can_issue = rst_n_i & can_load & (count < CW'(DEPTH));
    assign empty     = (count == '0);

    // Scan lowest priority first so the highest-priority valid wins last.
    always_comb begin
        win_vld = 1'b0;
        win     = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (req_v[rr_idx(rr_ptr, 2'(i))]) begin
                win_vld = 1'b1;
                win     = rr_idx(rr_ptr, 2'(i));
            end
        end
    end

    assign grant = (can_issue & win_vld) ? (3'b001 << win) : 3'b000;
    assign push  = |grant;
    assign ch0_req_allowIn_o = grant[0];
    assign ch1_req_allowIn_o = grant[1];
    assign ch2_req_allowIn_o = grant[2];

    assign head    = fifo[rd_ptr];
    assign head_oh = 3'b001 << head;
    assign {ch2_rtn_valid_o, ch1_rtn_valid_o, ch0_rtn_valid_o} =
        (pipe_rtn_valid_i & !empty) ? head_oh : 3'b000;
    assign pipe_rtn_ready_o = empty | (|(rtn_rdy & head_oh));
    assign pop = pipe_rtn_valid_i & pipe_rtn_ready_o & !empty;
    assign ch0_rtn_data_o = pipe_rtn_data_i;
    assign ch1_rtn_data_o = pipe_rtn_data_i;
    assign ch2_rtn_data_o = pipe_rtn_data_i;
    assign outstanding_o  = count;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pipe_req_valid_o <= 1'b0;
            pipe_req_op_o    <= '0;
            pipe_req_addr_o  <= '0;
            pipe_req_data_o  <= '0;
            pipe_req_chid_o  <= '0;
            rr_ptr           <= 2'd0;
        end else if (push) begin
            pipe_req_valid_o <= 1'b1;
            pipe_req_op_o    <= op_a[win];
            pipe_req_addr_o  <= addr_a[win];
            pipe_req_data_o  <= data_a[win];
            pipe_req_chid_o  <= win;
            rr_ptr           <= rr_idx(win, 2'd1);
        end else if (xfer) begin
            pipe_req_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) fifo[i] <= 2'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= win;
                wr_ptr       <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push & !pop) count <= count + CW'(1);
            else if (pop & !push) count <= count - CW'(1);
            // Orphan beats are swallowed; the flag stays until reset.
            if (pipe_rtn_valid_i & empty) err_o <= 1'b1;
        end
    end

endmodule
